tricolor_exerciser: RTL

- Hardware counterpart of the `tricolor` comparator bench: generates `a`/`b` operand pairs, drives them into a `tricolor` instance, samples `red`/`green`/`blue`, and checks each response against the golden rule:
  - `red` = a>b
  - `green` = a==b
  - `blue` = a<b
- Sits beside the comparator on the FPGA as a built-in self-test engine, reporting pass/error counts and the first-class detail of each mismatch.

---
 rtl/tricolor_pkg.sv | 33 +++
 rtl/tricolor_lfsr.sv | 28 ++
 rtl/tricolor_exerciser.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tricolor_pkg.sv
// tricolor_pkg: shared types and helpers for the tricolor
// self-test engine (states, response struct, golden rule).
package tricolor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } rgb_t;

  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic rgb_t expected_rgb(
    input logic [1:0] a,
    input logic [1:0] b
  );
    rgb_t r;
    r.red   = (a > b);
    r.green = (a == b);
    r.blue  = (a < b);
    return r;
  endfunction

endpackage

// File: rtl/tricolor_lfsr.sv
// tricolor_lfsr: 8-bit Fibonacci LFSR, steps when en is high;
// exposes the low nibble used as the {a,b} operand pair.
module tricolor_lfsr
  import tricolor_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] vec
);

  logic [7:0] q;
  logic       fb;

  assign fb  = ^(q & LFSR_TAPS);
  assign vec = q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/tricolor_exerciser.sv
// tricolor_exerciser: BIST engine that drives a/b into a tricolor
// comparator, samples red/green/blue and counts pass/error.
module tricolor_exerciser
  import tricolor_pkg::*;
#(
  parameter int         N_RANDOM  = 10,
  parameter int         SETTLE    = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic [1:0] a,
  output logic [1:0] b,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] err_cnt,
  output logic       err_valid,
  output logic [6:0] err_vec
);

  localparam logic [7:0]  NR     = 8'(N_RANDOM);
  localparam logic [15:0] SET_LD = 16'(SETTLE - 1);

  state_t      state, nstate;
  logic        mode_q;
  logic [7:0]  idx;
  logic [7:0]  total;
  logic [15:0] scnt;
  logic        last;
  logic        lfsr_en;
  logic [3:0]  rvec;
  rgb_t        resp;
  logic        mismatch;

  tricolor_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (lfsr_en),
    .vec  (rvec)
  );

  assign total    = mode_q ? NR : 8'd16;
  assign last     = (idx == total - 8'd1);
  assign resp     = '{red: red, green: green, blue: blue};
  // expected is one-hot, so any non-one-hot response mismatches
  assign mismatch = (resp != expected_rgb(a, b));

  assign busy = (state == S_DRIVE) ||
                (state == S_SETTLE) ||
                (state == S_CHECK);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate  = state;
    lfsr_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nstate = (mode && NR == 8'd0) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE: begin
        nstate  = S_SETTLE;
        lfsr_en = mode_q;
      end
      S_SETTLE: begin
        if (scnt == 16'd0) nstate = S_CHECK;
      end
      S_CHECK: begin
        nstate = last ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      idx       <= '0;
      scnt      <= '0;
      a         <= '0;
      b         <= '0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      err_vec   <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            pass_cnt <= '0;
            err_cnt  <= '0;
            idx      <= '0;
          end
        end
        S_DRIVE: begin
          {a, b} <= mode_q ? rvec : idx[3:0];
          scnt   <= SET_LD;
        end
        S_SETTLE: begin
          if (scnt != 16'd0) scnt <= scnt - 16'd1;
        end
        S_CHECK: begin
          idx <= idx + 8'd1;
          if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            err_valid <= 1'b1;
            err_vec   <= {a, b, resp};
          end else if (pass_cnt != 8'hFF) begin
            pass_cnt <= pass_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
